// File: rtl/periph_bus_bridge.sv
// Peripheral bus bridge: decodes the peripheral region, drives one chip
// select per slot, waits for ready or times out, and returns read data.
module periph_bus_bridge #(
  parameter int NSLAVES    = 4,
  parameter int REGION_BIT = 11,
  parameter int SLOT_SHIFT = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_data_i,
  input  logic [3:0]            req_wmask_i,
  input  logic                  req_wen_i,
  output logic                  stall_o,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  output logic                  bus_err_o,
  output logic [31:0]           err_addr_o,
  output logic [NSLAVES-1:0]    p_csb_o,
  output logic [31:0]           p_addr_o,
  output logic [31:0]           p_data_o,
  output logic [3:0]            p_wmask_o,
  output logic                  p_wen_o,
  input  logic [32*NSLAVES-1:0] p_rdata_i,
  input  logic [NSLAVES-1:0]    p_ready_i
);

  localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SEL_W:0] NS_L    = (SEL_W + 1)'(NSLAVES);
  localparam logic [CW-1:0]  TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] slot_q;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      rsp_data_d;
  logic             latch;

  logic             hit;
  logic [SEL_W-1:0] req_slot;
  logic             req_mapped;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             timed_out;

  assign hit        = req_valid_i & req_addr_i[REGION_BIT];
  assign req_slot   = req_addr_i[SLOT_SHIFT +: SEL_W];
  assign req_mapped = ({1'b0, req_slot} < NS_L);
  assign timed_out  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Mux the selected slave's ready/data and decode its chip select.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    p_csb_o   = '1;
    for (int k = 0; k < NSLAVES; k++) begin
      if (slot_q == SEL_W'(k)) begin
        sel_ready = p_ready_i[k];
        sel_rdata = p_rdata_i[32*k +: 32];
        if (state_q == S_ACCESS) begin
          p_csb_o[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_o;
    latch      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          latch = 1'b1;
          cnt_d = '0;
          if (req_mapped) begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_d      = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        if (sel_ready) begin
          err_d      = 1'b0;
          rsp_data_d = p_wen_o ? sel_rdata : '0;
          state_d    = S_RESP;
        end else if (timed_out) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_data_o <= '0;
      err_addr_o <= '0;
      p_addr_o   <= '0;
      p_data_o   <= '0;
      p_wmask_o  <= '0;
      p_wen_o    <= 1'b1;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      rsp_data_o <= rsp_data_d;
      if (latch) begin
        slot_q    <= req_slot;
        p_addr_o  <= req_addr_i;
        p_data_o  <= req_data_i;
        p_wmask_o <= req_wmask_i;
        p_wen_o   <= req_wen_i;
      end
      if (state_q == S_RESP && err_q) begin
        err_addr_o <= p_addr_o;
      end
    end
  end

  // Stall drops with reset so a held core request is released at once.
  assign stall_o = reset_i &
    (((state_q == S_IDLE) & hit) | (state_q == S_ACCESS));
  assign rsp_valid_o = (state_q == S_RESP);
  assign bus_err_o   = (state_q == S_RESP) & err_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: directed scenarios plus
// randomized accesses checked against a transaction-level model.
module tb_periph_bus_bridge;

  localparam int T = 15;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid3 = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_wmask = '0;
  logic        req_wen = 1'b1;

  logic        stall_o, rsp_valid_o, bus_err_o, p_wen_o;
  logic [31:0] rsp_data_o, err_addr_o, p_addr_o, p_data_o;
  logic [3:0]  p_wmask_o, p_csb_o;
  logic [3:0]  p_ready = '0;
  logic [31:0] word [4];
  logic [127:0] p_rdata;

  logic        stall3, rsp_valid3, bus_err3, p_wen3;
  logic [31:0] rsp_data3, err_addr3, p_addr3, p_data3;
  logic [3:0]  p_wmask3;
  logic [2:0]  p_csb3;
  logic [2:0]  p_ready3 = '0;
  logic [95:0] p_rdata3 = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_err_addr = '0;

  always #5 clk_i = ~clk_i;

  assign p_rdata = {word[3], word[2], word[1], word[0]};

  periph_bus_bridge dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_wmask_i (req_wmask),
    .req_wen_i   (req_wen),
    .stall_o     (stall_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .bus_err_o   (bus_err_o),
    .err_addr_o  (err_addr_o),
    .p_csb_o     (p_csb_o),
    .p_addr_o    (p_addr_o),
    .p_data_o    (p_data_o),
    .p_wmask_o   (p_wmask_o),
    .p_wen_o     (p_wen_o),
    .p_rdata_i   (p_rdata),
    .p_ready_i   (p_ready)
  );

  periph_bus_bridge #(.NSLAVES(3)) dut3 (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid3),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_wmask_i (req_wmask),
    .req_wen_i   (req_wen),
    .stall_o     (stall3),
    .rsp_valid_o (rsp_valid3),
    .rsp_data_o  (rsp_data3),
    .bus_err_o   (bus_err3),
    .err_addr_o  (err_addr3),
    .p_csb_o     (p_csb3),
    .p_addr_o    (p_addr3),
    .p_data_o    (p_data3),
    .p_wmask_o   (p_wmask3),
    .p_wen_o     (p_wen3),
    .p_rdata_i   (p_rdata3),
    .p_ready_i   (p_ready3)
  );

  // Acts as core and slave for one access; records what it observed.
  task automatic xfer(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  int          rdy_at,
    input  bit          noise,
    input  int          maxc,
    output int          n_stall,
    output int          n_low,
    output logic [3:0]  csb_pat,
    output logic [31:0] pa,
    output logic [31:0] pd,
    output logic [3:0]  pm,
    output logic        pw,
    output bit          got,
    output int          lat,
    output logic [31:0] rd,
    output logic        er
  );
    int slot;
    slot = int'(addr[5:4]);
    n_stall = 0; n_low = 0; csb_pat = 4'hF;
    pa = '0; pd = '0; pm = '0; pw = 1'b1;
    got = 1'b0; lat = -1; rd = 'x; er = 1'bx;
    @(negedge clk_i);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_wmask = wmask;
    req_wen   = wen;
    for (int c = 0; c < maxc; c++) begin
      #1;
      if (stall_o) n_stall++;
      p_ready = '0;
      if (p_csb_o != 4'hF) begin
        n_low++;
        if (n_low == 1) csb_pat = p_csb_o;
        pa = p_addr_o; pd = p_data_o;
        pm = p_wmask_o; pw = p_wen_o;
        if (n_low == rdy_at) p_ready[slot] = 1'b1;
      end
      if (noise)
        p_ready = p_ready | (4'($urandom) & ~(4'b1 << slot));
      if (rsp_valid_o) begin
        got = 1'b1;
        lat = c;
        rd  = rsp_data_o;
        er  = bus_err_o;
        req_valid = 1'b0;
        p_ready = '0;
        break;
      end
      @(negedge clk_i);
    end
    req_valid = 1'b0;
    p_ready = '0;
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({stall_o, rsp_valid_o, bus_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {stall_o, rsp_valid_o, bus_err_o});
    end
    checks++;
    if (p_csb_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_csb: got %b want 1111", p_csb_o);
    end
    checks++;
    if (rsp_data_o !== 32'h0 || err_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: got %h/%h want 0/0",
               rsp_data_o, err_addr_o);
    end
    checks++;
    if ({p_addr_o, p_data_o, p_wmask_o} !== '0 || p_wen_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_preg: got %h %h %h %b want 0 0 0 1",
               p_addr_o, p_data_o, p_wmask_o, p_wen_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_read;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    word[1] = 32'hDEADBEEF;
    xfer(32'h810, 32'h0, 4'h0, 1'b1, 1, 1'b0, 10,
         ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
    checks++;
    if (nl !== 1 || cp !== 4'b1101) begin
      errors++;
      $display("FAIL read_csb: got %0d x %b want 1 x 1101", nl, cp);
    end
    checks++;
    if (ns !== 2) begin
      errors++;
      $display("FAIL read_stall: got %0d want 2", ns);
    end
    checks++;
    if (!got || lat !== 2) begin
      errors++;
      $display("FAIL read_latency: got %0d/%0d want 1/2", got, lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL read_data: got %h err %b want deadbeef err 0",
               rd, er);
    end
  endtask

  task automatic test_write;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    word[0] = 32'hCAFEF00D;
    xfer(32'h800, 32'h55, 4'b0001, 1'b0, 3, 1'b0, 12,
         ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
    checks++;
    if (nl !== 3 || cp !== 4'b1110) begin
      errors++;
      $display("FAIL write_csb: got %0d x %b want 3 x 1110", nl, cp);
    end
    checks++;
    if (pd !== 32'h55 || pw !== 1'b0 || pm !== 4'b0001 ||
        pa !== 32'h800) begin
      errors++;
      $display("FAIL write_preg: got %h %b %b %h want 55 0 0001 800",
               pd, pw, pm, pa);
    end
    checks++;
    if (!got || lat !== 4 || rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: got %0d lat %0d %h %b want 1 4 0 0",
               got, lat, rd, er);
    end
  endtask

  task automatic test_nonhit;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    xfer(32'h400, 32'h0, 4'h0, 1'b1, 1, 1'b0, 5,
         ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
    checks++;
    if (ns !== 0 || nl !== 0 || got !== 1'b0) begin
      errors++;
      $display("FAIL nonhit: got stall %0d csb %0d rsp %0d want 0 0 0",
               ns, nl, got);
    end
  endtask

  task automatic test_unmapped;
    @(negedge clk_i);
    req_addr = 32'h830;
    req_wen = 1'b1;
    req_valid3 = 1'b1;
    #1;
    checks++;
    if (stall3 !== 1'b1 || p_csb3 !== 3'b111) begin
      errors++;
      $display("FAIL unmap_accept: got %b %b want 1 111", stall3, p_csb3);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({rsp_valid3, bus_err3, stall3} !== 3'b110 ||
        p_csb3 !== 3'b111 || rsp_data3 !== 32'h0) begin
      errors++;
      $display("FAIL unmap_rsp: got %b %b %h want 110 111 0",
               {rsp_valid3, bus_err3, stall3}, p_csb3, rsp_data3);
    end
    req_valid3 = 1'b0;
    @(negedge clk_i);
    #1;
    checks++;
    if (err_addr3 !== 32'h830 || rsp_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL unmap_erraddr: got %h %b want 830 0",
               err_addr3, rsp_valid3);
    end
  endtask

  task automatic test_timeout;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    word[3] = 32'h12345678;
    xfer(32'h830, 32'h0, 4'h0, 1'b1, 0, 1'b0, 40,
         ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
    exp_err_addr = 32'h830;
    checks++;
    if (nl !== T || ns !== T + 1) begin
      errors++;
      $display("FAIL timeout_len: got %0d/%0d want %0d/%0d",
               nl, ns, T, T + 1);
    end
    checks++;
    if (!got || lat !== T + 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL timeout_rsp: got %0d lat %0d err %b %h want 1 %0d 1 0",
               got, lat, er, rd, T + 1);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (err_addr_o !== exp_err_addr) begin
      errors++;
      $display("FAIL timeout_erraddr: got %h want %h",
               err_addr_o, exp_err_addr);
    end
    xfer(32'h834, 32'h0, 4'h0, 1'b1, T, 1'b0, 40,
         ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
    checks++;
    if (!got || nl !== T || er !== 1'b0 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL ready_at_limit: got %0d %0d err %b %h want 1 %0d 0 12345678",
               got, nl, er, rd, T);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (err_addr_o !== exp_err_addr) begin
      errors++;
      $display("FAIL erraddr_sticky: got %h want %h",
               err_addr_o, exp_err_addr);
    end
  endtask

  task automatic test_reset_mid;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    int seen;
    seen = 0;
    @(negedge clk_i);
    req_addr = 32'h820; req_wen = 1'b1; req_valid = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (p_csb_o !== 4'b1011) begin
      errors++;
      $display("FAIL mid_pre: got %b want 1011", p_csb_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (p_csb_o !== 4'hF || stall_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b %b %b want 1111 0 0",
               p_csb_o, stall_o, rsp_valid_o);
    end
    req_valid = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      #1;
      if (rsp_valid_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_dropped: got %0d rsp pulses want 0", seen);
    end
    word[2] = 32'hA5A50F0F;
    xfer(32'h820, 32'h0, 4'h0, 1'b1, 2, 1'b0, 12,
         ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
    checks++;
    if (!got || lat !== 3 || rd !== 32'hA5A50F0F || er !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got %0d lat %0d %h %b want 1 3 a5a50f0f 0",
               got, lat, rd, er);
    end
  endtask

  task automatic test_back_to_back;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    for (int i = 0; i < 3; i++) begin
      word[i] = $urandom;
      xfer(32'h800 | (32'(i) << 4), 32'h0, 4'h0, 1'b1, 1, 1'b0, 8,
           ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
      checks++;
      if (!got || lat !== 2 || ns !== 2 || rd !== word[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got %0d lat %0d stall %0d %h want 1 2 2 %h",
                 i, got, lat, ns, rd, word[i]);
      end
    end
  endtask

  // Model: a mapped access ends on the ready cycle if it falls within
  // T access cycles, otherwise errors after exactly T cycles.
  task automatic test_random;
    int ns, nl, lat; logic [3:0] cp, pm; logic [31:0] pa, pd, rd;
    logic pw, er; bit got;
    logic [31:0] addr, data; logic wen; int slot, rdy, k;
    bit hit, e_err; logic [31:0] e_rd;
    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < 4; s++) word[s] = $urandom;
      addr = $urandom;
      data = $urandom;
      wen  = 1'($urandom);
      hit  = ($urandom_range(0, 4) != 0);
      addr[11] = hit;
      slot = int'(addr[5:4]);
      rdy  = $urandom_range(0, T + 2);
      xfer(addr, data, 4'($urandom), wen, rdy, 1'b1, hit ? 25 : 4,
           ns, nl, cp, pa, pd, pm, pw, got, lat, rd, er);
      if (!hit) begin
        checks++;
        if (ns !== 0 || nl !== 0 || got !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_nonhit: got %0d %0d %0d want 0 0 0",
                   it, ns, nl, got);
        end
      end else begin
        e_err = !(rdy >= 1 && rdy <= T);
        k     = e_err ? T : rdy;
        e_rd  = (e_err || !wen) ? 32'h0 : word[slot];
        if (e_err) exp_err_addr = addr;
        checks++;
        if (!got || lat !== k + 1 || ns !== k + 1 || nl !== k) begin
          errors++;
          $display("FAIL rnd%0d_timing: got %0d lat %0d st %0d low %0d want lat/st %0d low %0d",
                   it, got, lat, ns, nl, k + 1, k);
        end
        checks++;
        if (cp !== ~(4'b1 << slot) || pa !== addr || pd !== data ||
            pw !== wen) begin
          errors++;
          $display("FAIL rnd%0d_bus: got %b %h %h %b want %b %h %h %b",
                   it, cp, pa, pd, pw, ~(4'b1 << slot), addr, data, wen);
        end
        checks++;
        if (rd !== e_rd || er !== e_err) begin
          errors++;
          $display("FAIL rnd%0d_rsp: got %h err %b want %h err %b",
                   it, rd, er, e_rd, e_err);
        end
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (err_addr_o !== exp_err_addr) begin
        errors++;
        $display("FAIL rnd%0d_erraddr: got %h want %h",
                 it, err_addr_o, exp_err_addr);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) word[s] = '0;
    test_reset();
    test_read();
    test_write();
    test_nonhit();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
